seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream consumer of a CPU-written 32-bit MMIO output register (CPU store -> bridge -> register -> this block).
//  Shows the latched word as 8 hex digits on a multiplexed 7-segment display with active-low segments and anodes.
//  Drives board pins directly; value updates are tear-free (frame-aligned).
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per digit slot (>= GUARD_CYCLES+2)
//  GUARD_CYCLES  16     cycles at slot start with all anodes off (anti-ghosting)
//  NUM_DIGITS    8      digits scanned, 1..8; digit k shows value[4k+3:4k]
// PORTS
//  clk      in   1           system clock
//  reset    in   1           asynchronous, active-low reset
//  value    in   32          word from the upstream output register
//  load     in   1           1-cycle strobe: value is new (same-cycle as the register write)
//  blank    in   1           level: 1 = display dark
//  seg_n    out  8           {dp,g,f,e,d,c,b,a}, active-low
//  an_n     out  NUM_DIGITS  digit enables, active-low, at most one low
//  frame    out  1           1-cycle pulse at each frame boundary (shadow update point)
// BEHAVIOUR
//  Reset (reset==0, async): seg_n=8'hFF, an_n=all 1, frame=0, shadow=0, pend=0, div=0, idx=0, state=BLANK.
//  Divider: div counts 0..SCAN_DIV-1, wraps; on wrap idx=(idx+1)%NUM_DIGITS. Counters free-run, also while blanked.
//  Frame end: div==SCAN_DIV-1 && idx==NUM_DIGITS-1; that cycle frame<=1 (next cycle).
//  Load: load=1 -> pend_val<=value, pend<=1; repeated loads before frame end: last wins.
//  Shadow: at frame end, if load: shadow<=value (same-cycle load is taken directly);
//   else if pend: shadow<=pend_val; pend cleared in both cases.
//  FSM (3 states): BLANK -> GUARD at first slot boundary (div wrap) with blank==0;
//   GUARD -> DRIVE when div==GUARD_CYCLES-1; DRIVE -> GUARD on div wrap;
//   any state -> BLANK on blank==1 (takes effect next cycle).
//  Outputs registered, 1-cycle latency from state/idx:
//   BLANK/GUARD: an_n all 1, seg_n=8'hFF. DRIVE: an_n[idx]=0, seg_n=decode(shadow nibble idx), dp off.
//  Decode: standard hex 0-9,A,b,C,d,E,F; active-low (0 -> 7'b1000000 as {g..a}).
//  Boundaries: blank mid-slot -> dark next cycle, no partial re-enable; blank release ->
//   dark until next slot boundary + GUARD; NUM_DIGITS=1 -> frame end every slot;
//   reset mid-frame -> all state to reset values immediately, pending value discarded.
// CONFIGURATION
//  SEG7_LZ_SUPPRESS_EN defined: in DRIVE, digit idx>0 whose nibble and all higher
//   displayed nibbles are 0 stays dark (an_n all 1); digit 0 always shown (value 0 -> "0").
//  Not defined: all NUM_DIGITS digits always shown, leading zeros included.
// STRUCTURE
//  seg7_defs.vh: FSM state localparams (BLANK/GUARD/DRIVE), SEG_OFF=8'hFF, hex->segment table.
//  Sub-module seg7_hex_decode: combinational 4-bit nibble -> 7-bit active-low segments.
//  Top holds divider, idx, shadow/pend regs, FSM, output regs.
// TESTING (sim with SCAN_DIV=4, GUARD_CYCLES=1, NUM_DIGITS=8)
//  Reset low mid-scan -> seg_n=FF, an_n=FF immediately; after release, first anode low at cycle 6.
//  load 32'h1234ABCD, blank=0 -> after next frame: slot0 an_n=FE seg_n=A1 ('d'), slot7 an_n=7F seg_n=F9 ('1').
//  Loads 32'h11111111 then 32'h22222222 in one frame -> next frame shows only 2s, never 1s.
//  load 32'h000000FF on frame-end cycle -> that word used in the very next frame.
//  blank=1 during DRIVE -> an_n=FF next cycle; release -> dark until slot boundary + 1 guard cycle.
//  SEG7_LZ_SUPPRESS_EN, value 32'h0000_00A0 -> digits 0,1 lit ("A0"), digits 2..7 dark; value 0 -> only digit 0 "0".

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 7-segment scan driver: FSM state encodings,
// the all-dark segment pattern and the hex -> segment lookup.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   ST_BLANK / ST_GUARD / ST_DRIVE  scan FSM state encodings
//   SEG_OFF                         {dp,g..a} pattern with every segment dark
//   hex_to_seg()                    4-bit nibble -> 7-bit active-low {g..a}
package seg7_scan_driver_pkg;

  // Scan FSM states. Plain constants keep the encoding visible in waveforms
  // and compatible with older tool flows.
  localparam logic [1:0] ST_BLANK = 2'd0;  // display dark, waiting for a slot boundary
  localparam logic [1:0] ST_GUARD = 2'd1;  // slot start, anodes held off (anti-ghosting)
  localparam logic [1:0] ST_DRIVE = 2'd2;  // current digit lit

  // All segments (including dp) dark; segments are active-low.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Standard hex glyphs 0-9, A, b, C, d, E, F as active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;  // F
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble -> 7-segment decoder (active-low segments).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
//
// Ports:
//   nib_i    in   4   hex digit to display
//   seg_n_o  out  7   {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit hex display driver for a CPU-written 32-bit output word.
// Latency: outputs registered, 1 cycle behind the scan state; a loaded word
//   appears from the first frame boundary after the load (tear-free).
// Backpressure: none; loads are always accepted, last load before a frame boundary wins.
//
// Ports:
//   clk     in   1           system clock
//   reset   in   1           asynchronous, active-low reset
//   value   in   32          word from the upstream output register
//   load    in   1           1-cycle strobe, value is new
//   blank   in   1           level, 1 = display dark
//   seg_n   out  8           {dp,g,f,e,d,c,b,a}, active-low
//   an_n    out  NUM_DIGITS  digit enables, active-low, at most one low
//   frame   out  1           1-cycle pulse after each frame boundary (shadow update)
//
// Build option: define SEG7_LZ_SUPPRESS_EN to keep leading-zero digits dark
//   (digit 0 is always shown). Without it every digit is always shown.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,  // clk cycles per digit slot, >= GUARD_CYCLES+2
  parameter int GUARD_CYCLES = 16,     // dark cycles at the start of each slot
  parameter int NUM_DIGITS   = 8       // 1..8, digit k shows value[4k+3:4k]
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           value,
  input  logic                  load,
  input  logic                  blank,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]      div_q,      div_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [1:0]            state_q,    state_d;
  logic [31:0]           shadow_q,   shadow_d;
  logic [31:0]           pend_val_q, pend_val_d;
  logic                  pend_q,     pend_d;
  logic [7:0]            seg_n_q,    seg_n_d;
  logic [NUM_DIGITS-1:0] an_n_q,     an_n_d;
  logic                  frame_q,    frame_d;

  logic                  div_wrap;
  logic                  idx_last;
  logic                  frame_end;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg_n;
  logic                  suppress;

  // ---------------------------------------------------------------------------
  // Slot divider and digit index. Both free-run, including while blanked, so
  // the frame cadence (and therefore shadow updates) never depends on blank.
  // ---------------------------------------------------------------------------
  always_comb begin
    div_wrap  = (div_q == DIV_W'(SCAN_DIV - 1));
    idx_last  = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_end = div_wrap && idx_last;

    div_d = div_wrap ? '0 : div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_wrap) begin
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / shadow value. The shadow only changes on the frame-end edge so a
  // frame never mixes digits from two different words. A load that coincides
  // with frame end bypasses the pending register and is used straight away.
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_d   = shadow_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (frame_end) begin
      pend_d = 1'b0;
      if (load) begin
        shadow_d = value;
      end else if (pend_q) begin
        shadow_d = pend_val_q;
      end
    end else if (load) begin
      pend_val_d = value;
      pend_d     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM. Leaving BLANK waits for a slot boundary so a release never lights
  // a partial slot; every slot then begins with GUARD_CYCLES of dark anodes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (blank) begin
      state_d = ST_BLANK;
    end else begin
      case (state_q)
        ST_BLANK: if (div_wrap)                              state_d = ST_GUARD;
        ST_GUARD: if (div_q == DIV_W'(GUARD_CYCLES - 1))     state_d = ST_DRIVE;
        ST_DRIVE: if (div_wrap)                              state_d = ST_GUARD;
        default:                                             state_d = ST_BLANK;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Digit data for the current index
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = shadow_q[4*k +: 4];
      end
    end
  end

  seg7_hex_decode u_hex_decode (
    .nib_i   (cur_nib),
    .seg_n_o (cur_seg_n)
  );

`ifdef SEG7_LZ_SUPPRESS_EN
  // A digit above position 0 is a leading zero when it and every higher
  // displayed nibble are zero.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx_q)) && (shadow_q[4*k +: 4] != 4'h0)) begin
        higher_zero = 1'b0;
      end
    end
    suppress = (idx_q != '0) && higher_zero;
  end
`else
  assign suppress = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output stage. blank is also applied here directly so the display goes dark
  // on the very next cycle, not after the FSM has first moved to BLANK.
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_n_d = SEG_OFF;
    an_n_d  = '1;
    frame_d = frame_end;
    if (!blank && (state_q == ST_DRIVE) && !suppress) begin
      seg_n_d = {1'b1, cur_seg_n};  // decimal point always off
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          an_n_d[k] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      idx_q      <= '0;
      state_q    <= ST_BLANK;
      shadow_q   <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      seg_n_q    <= SEG_OFF;
      an_n_q     <= '1;
      frame_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      seg_n_q    <= seg_n_d;
      an_n_q     <= an_n_d;
      frame_q    <= frame_d;
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, GUARD_CYCLES=1, NUM_DIGITS=8.
// One frame is 32 cycles. After a frame pulse (c=0, div=0, idx=0) digit k is
// observed lit at c = 4k+2. Inputs change and outputs are sampled 1 ns after posedge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic        load;
  logic        blank;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;
  logic        frame;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_driver #(
    .SCAN_DIV     (4),
    .GUARD_CYCLES (1),
    .NUM_DIGITS   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .blank (blank),
    .seg_n (seg_n),
    .an_n  (an_n),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick();
  endtask

  task automatic check_slot(input string tag, input logic [7:0] an_exp, input logic [7:0] seg_exp);
    check_eq({tag, "_an"}, {24'h0, an_n}, {24'h0, an_exp});
    check_eq({tag, "_seg"}, {24'h0, seg_n}, {24'h0, seg_exp});
  endtask

  // Advance until the frame pulse is seen (bounded), leaving the bench at c=0.
  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (frame === 1'b1) seen = 1'b1;
    end
    check_eq("frame_seen", {31'h0, seen}, 32'h1);
  endtask

  // Called right after reset is released between edges with blank=0:
  // dark for five edges, first anode (digit 1) low on the sixth.
  task automatic startup(input string tag);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq({tag, "_dark"}, {24'h0, an_n}, 32'hFF);
    end
    tick();
`ifdef SEG7_LZ_SUPPRESS_EN
    check_slot({tag, "_c6"}, 8'hFF, 8'hFF);  // shadow is 0, digit 1 is a leading zero
`else
    check_slot({tag, "_c6"}, 8'hFD, 8'hC0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    blank = 1'b0;
    value = 32'h0;

    // Reset state
    skip(3);
    check_slot("rst", 8'hFF, 8'hFF);
    check_eq("rst_frame", {31'h0, frame}, 32'h0);

    reset = 1'b1;
    startup("boot");

    // Basic load, shown from the next frame
    value = 32'h1234ABCD;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    wait_frame();                               // c=0
    tick();                                     // c=1
    check_eq("frame_width", {31'h0, frame}, 32'h0);
    check_eq("guard_dark", {24'h0, an_n}, 32'hFF);
    tick();                                     // c=2
    check_slot("a_slot0", 8'hFE, 8'hA1);        // 'd'
    skip(8);                                    // c=10
    check_slot("a_slot2", 8'hFB, 8'h83);        // 'b'
    skip(8);                                    // c=18
    check_slot("a_slot4", 8'hEF, 8'h99);        // '4'
    skip(12);                                   // c=30
    check_slot("a_slot7", 8'h7F, 8'hF9);        // '1'

    // Two loads in one frame: last wins
    wait_frame();                               // c=0
    value = 32'h11111111;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    tick();
    value = 32'h22222222;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    wait_frame();                               // c=0
    skip(2);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] an_exp;
      an_exp    = 8'hFF;
      an_exp[k] = 1'b0;
      if (k != 0) skip(4);
      check_slot("b_slot", an_exp, 8'hA4);      // '2' on every digit
    end                                         // ends at c=30

    // Load on the frame-end cycle is used in the very next frame
    tick();                                     // c=31, frame-end cycle
    value = 32'h000000FF;
    load  = 1'b1;
    tick();                                     // c=0
    load  = 1'b0;
    check_eq("c_frame", {31'h0, frame}, 32'h1);
    skip(2);
    check_slot("c_slot0", 8'hFE, 8'h8E);        // 'F'
    skip(4);
    check_slot("c_slot1", 8'hFD, 8'h8E);
    skip(4);
`ifdef SEG7_LZ_SUPPRESS_EN
    check_slot("c_slot2", 8'hFF, 8'hFF);
`else
    check_slot("c_slot2", 8'hFB, 8'hC0);
`endif

    // Blank mid-slot, then release at the slot's last cycle
    wait_frame();
    skip(2);                                    // c=2
    check_slot("d_lit", 8'hFE, 8'h8E);
    blank = 1'b1;
    tick();                                     // c=3
    check_slot("d_blank", 8'hFF, 8'hFF);
    blank = 1'b0;
    tick();                                     // c=4, slot boundary just passed
    check_slot("d_rel0", 8'hFF, 8'hFF);
    tick();                                     // c=5, guard
    check_slot("d_rel1", 8'hFF, 8'hFF);
    tick();                                     // c=6
    check_slot("d_relit", 8'hFD, 8'h8E);

    // Leading zeros: 0x000000A0
    value = 32'h000000A0;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    wait_frame();
    skip(2);
    check_slot("e_slot0", 8'hFE, 8'hC0);
    skip(4);
    check_slot("e_slot1", 8'hFD, 8'h88);        // 'A'
    skip(4);
`ifdef SEG7_LZ_SUPPRESS_EN
    check_slot("e_slot2", 8'hFF, 8'hFF);
`else
    check_slot("e_slot2", 8'hFB, 8'hC0);
`endif
    skip(20);                                   // c=30
`ifdef SEG7_LZ_SUPPRESS_EN
    check_slot("e_slot7", 8'hFF, 8'hFF);
`else
    check_slot("e_slot7", 8'h7F, 8'hC0);
`endif

    // Value 0 via pend one cycle before frame end
    value = 32'h0;
    load  = 1'b1;
    tick();                                     // c=31
    load  = 1'b0;
    tick();                                     // c=0
    check_eq("e0_frame", {31'h0, frame}, 32'h1);
    skip(2);
    check_slot("e0_slot0", 8'hFE, 8'hC0);
    skip(4);                                    // c=6
`ifdef SEG7_LZ_SUPPRESS_EN
    check_slot("e0_slot1", 8'hFF, 8'hFF);
`else
    check_slot("e0_slot1", 8'hFD, 8'hC0);
`endif

    // Reset mid-frame with a pending value: immediate dark, pending discarded
    value = 32'h55555555;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_slot("f_rst", 8'hFF, 8'hFF);
    check_eq("f_rst_frame", {31'h0, frame}, 32'h0);
    skip(2);
    reset = 1'b1;
    startup("reboot");
    wait_frame();
    skip(2);
    check_slot("f_slot0", 8'hFE, 8'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
